// File: rtl/wb_walk_master.sv
// Wishbone pipelined walk master: one start write, then paced status reads
// until a read returns zero (done) or a poll/ack limit is hit (abort).
// Ports:
//   i_clk, i_reset        clock, async active-high reset
//   i_trigger, i_wdata    start request and the value for the start write
//   o_busy, o_done, o_err walk in progress, completion pulse, sticky abort flag
//   o_status              data captured on the most recent read ack
//   o_cyc/o_stb/o_we/o_addr/o_data, i_stall/i_ack/i_data  Wishbone initiator
// POLL_DELAY, ACK_TIMEOUT and MAX_POLLS are expected to be at least 1.
module wb_walk_master #(
    parameter int unsigned POLL_DELAY  = 4,
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned MAX_POLLS   = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_trigger,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_status,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic        o_addr,
    output logic [31:0] o_data,
    input  logic        i_stall,
    input  logic        i_ack,
    input  logic [31:0] i_data
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned PW = $clog2(MAX_POLLS + 1);
    localparam int unsigned DW = $clog2(POLL_DELAY + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WREQ  = 3'd1;
    localparam logic [2:0] S_WACK  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_RREQ  = 3'd4;
    localparam logic [2:0] S_RACK  = 3'd5;

    logic [2:0]    state, state_n;
    logic [TW-1:0] tcnt, tcnt_n, tcnt_inc;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic          busy_n, done_n, err_n, cyc_n, stb_n, we_n;
    logic [31:0]   status_n, data_n;
    logic          tmo;
    logic          abort;

    // The bus only ever targets a single register.
    assign o_addr = 1'b0;

    // Saturating timeout increment; tmo marks the last cycle allowed without an ack.
    assign tcnt_inc = (tcnt == TW'(ACK_TIMEOUT)) ? tcnt : tcnt + TW'(1);
    assign tmo      = (tcnt == TW'(ACK_TIMEOUT - 1));

    // Next-state and next-output logic; every register holds unless changed here.
    always_comb begin
        state_n  = state;
        tcnt_n   = tcnt;
        pcnt_n   = pcnt;
        dcnt_n   = dcnt;
        busy_n   = o_busy;
        done_n   = 1'b0;
        err_n    = o_err;
        status_n = o_status;
        cyc_n    = o_cyc;
        stb_n    = o_stb;
        we_n     = o_we;
        data_n   = o_data;
        abort    = 1'b0;

        case (state)
            S_IDLE: begin
                cyc_n = 1'b0;
                stb_n = 1'b0;
                we_n  = 1'b0;
                if (i_trigger) begin
                    state_n = S_WREQ;
                    data_n  = i_wdata;
                    busy_n  = 1'b1;
                    err_n   = 1'b0;
                    pcnt_n  = '0;
                    tcnt_n  = '0;
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                    we_n    = 1'b1;
                end
            end
            S_WREQ, S_RREQ: begin
                tcnt_n = tcnt_inc;
                if (!i_stall) begin
                    state_n = (state == S_WREQ) ? S_WACK : S_RACK;
                    stb_n   = 1'b0;
                end
                if (tmo) abort = 1'b1;
            end
            S_WACK: begin
                if (i_ack) begin
                    state_n = S_PAUSE;
                    cyc_n   = 1'b0;
                    we_n    = 1'b0;
                    dcnt_n  = '0;
                end else begin
                    tcnt_n = tcnt_inc;
                    if (tmo) abort = 1'b1;
                end
            end
            S_PAUSE: begin
                if (dcnt == DW'(POLL_DELAY - 1)) begin
                    state_n = S_RREQ;
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                    we_n    = 1'b0;
                    tcnt_n  = '0;
                    pcnt_n  = (pcnt == PW'(MAX_POLLS)) ? pcnt : pcnt + PW'(1);
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            S_RACK: begin
                if (i_ack) begin
                    status_n = i_data;
                    cyc_n    = 1'b0;
                    if (i_data == 32'd0) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else if (pcnt == PW'(MAX_POLLS)) begin
                        abort = 1'b1;
                    end else begin
                        state_n = S_PAUSE;
                        dcnt_n  = '0;
                    end
                end else begin
                    tcnt_n = tcnt_inc;
                    if (tmo) abort = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cyc_n   = 1'b0;
                stb_n   = 1'b0;
                we_n    = 1'b0;
            end
        endcase

        // Abort wins over any transition chosen above.
        if (abort) begin
            state_n = S_IDLE;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            we_n    = 1'b0;
            err_n   = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_IDLE;
            tcnt     <= '0;
            pcnt     <= '0;
            dcnt     <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_status <= '0;
            o_cyc    <= 1'b0;
            o_stb    <= 1'b0;
            o_we     <= 1'b0;
            o_data   <= '0;
        end else begin
            state    <= state_n;
            tcnt     <= tcnt_n;
            pcnt     <= pcnt_n;
            dcnt     <= dcnt_n;
            o_busy   <= busy_n;
            o_done   <= done_n;
            o_err    <= err_n;
            o_status <= status_n;
            o_cyc    <= cyc_n;
            o_stb    <= stb_n;
            o_we     <= we_n;
            o_data   <= data_n;
        end
    end

endmodule
